tt_input_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the top-level logic and feeds its dedicated-input bus. Each bit of a raw, asynchronous pin bus is synchronised, debounced and edge-detected. The result is a clean level bus plus one-cycle rise and fall pulses for downstream logic. An optional saturating event counter tallies debounced rising edges for status readout.

---
 rtl/tt_input_conditioner.sv | 100 ++++++++++
 tb/tb_tt_input_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tt_input_conditioner.sv
// Two-flop synchroniser, per-bit debounce and edge pulses for the dedicated-input bus.
// Optional saturating rising-edge counter is built when INPUT_COND_EVCNT_EN is defined.
module tt_input_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] raw_in,
   input  logic             clr_count,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [7:0]       event_count
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1_q, s_q;
   logic [WIDTH-1:0] clean_q, clean_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   // Synchroniser keeps running while disabled so s_q is current on re-enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s_q  <= '0;
      end else begin
         s1_q <= raw_in;
         s_q  <= s1_q;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!ena || (s_q[i] == clean_q[i])) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]   = '0;
            clean_d[i] = s_q[i];
            rise_d[i]  = s_q[i];
            fall_d[i]  = ~s_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clean_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign clean_out  = clean_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef INPUT_COND_EVCNT_EN
   logic [7:0] evcnt_q, evcnt_d;

   // Counts cycles with any rising pulse, not individual bits; clear has priority.
   always_comb begin
      evcnt_d = evcnt_q;
      if (clr_count)
         evcnt_d = 8'h00;
      else if ((rise_q != '0) && (evcnt_q != 8'hFF))
         evcnt_d = evcnt_q + 8'h01;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) evcnt_q <= 8'h00;
      else     evcnt_q <= evcnt_d;
   end

   assign event_count = evcnt_q;
`else
   logic unused_clr_count;
   assign unused_clr_count = clr_count;
   assign event_count      = 8'h00;
`endif

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Directed bench for tt_input_conditioner at default parameters; event_count
// expectations follow whether INPUT_COND_EVCNT_EN is defined for the build.
module tb_tt_input_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] raw_in;
   logic       clr_count;
   logic [7:0] clean_out, rise_pulse, fall_pulse, event_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

`ifdef INPUT_COND_EVCNT_EN
   localparam bit EV_ON = 1'b1;
`else
   localparam bit EV_ON = 1'b0;
`endif

   tt_input_conditioner dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .raw_in      (raw_in),
      .clr_count   (clr_count),
      .clean_out   (clean_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .event_count (event_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ev_exp();
      return EV_ON ? 8'(exp_cnt) : 8'h00;
   endfunction

   task automatic add_rise();
      if (exp_cnt < 255) exp_cnt++;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; raw_in = 8'h00; clr_count = 1'b0;
      #1;
      chk("rst_clean", clean_out, 8'h00);
      chk("rst_rise", rise_pulse, 8'h00);
      chk("rst_fall", fall_pulse, 8'h00);
      chk("rst_ev", event_count, 8'h00);
      tick(2);
      rst = 1'b0;
      tick(3);

      // clean edge on bit 0: accepted on the 18th edge after the first sample
      raw_in = 8'h01;
      tick(17);
      chk("lat_e17_clean", clean_out, 8'h00);
      tick(1);
      chk("lat_e18_clean", clean_out, 8'h01);
      chk("lat_e18_rise", rise_pulse, 8'h01);
      chk("lat_e18_fall", fall_pulse, 8'h00);
      chk("lat_e18_ev", event_count, ev_exp());
      add_rise();
      tick(1);
      chk("lat_e19_rise", rise_pulse, 8'h00);
      chk("lat_e19_ev", event_count, ev_exp());
      raw_in = 8'h00;
      tick(18);
      chk("fall0_pulse", fall_pulse, 8'h01);
      chk("fall0_clean", clean_out, 8'h00);
      tick(1);
      chk("fall0_ev", event_count, ev_exp());

      // 15-cycle glitch on bit 3 is rejected
      raw_in = 8'h08;
      tick(15);
      raw_in = 8'h00;
      for (int k = 0; k < 25; k++) begin
         tick(1);
         chk("glitch_clean", clean_out, 8'h00);
         chk("glitch_rise", rise_pulse, 8'h00);
      end
      chk("glitch_ev", event_count, ev_exp());

      // 16-cycle high on bit 3 is accepted
      raw_in = 8'h08;
      tick(16);
      raw_in = 8'h00;
      tick(2);
      chk("pulse16_clean", clean_out, 8'h08);
      chk("pulse16_rise", rise_pulse, 8'h08);
      add_rise();
      tick(1);
      chk("pulse16_ev", event_count, ev_exp());
      tick(20);
      chk("pulse16_back", clean_out, 8'h00);

      // multi-bit rise counts once; fall does not count
      raw_in = 8'hF0;
      tick(18);
      chk("multi_rise", rise_pulse, 8'hF0);
      chk("multi_clean", clean_out, 8'hF0);
      add_rise();
      tick(1);
      chk("multi_rise_end", rise_pulse, 8'h00);
      chk("multi_ev", event_count, ev_exp());
      raw_in = 8'h00;
      tick(18);
      chk("multi_fall", fall_pulse, 8'hF0);
      chk("multi_fall_rise", rise_pulse, 8'h00);
      chk("multi_fall_clean", clean_out, 8'h00);
      tick(1);
      chk("multi_fall_end", fall_pulse, 8'h00);
      chk("multi_fall_ev", event_count, ev_exp());

      // ena dropped at cnt=10 for 5 cycles restarts the count
      raw_in = 8'h02;
      tick(12);
      ena = 1'b0;
      tick(5);
      chk("ena_off_clean", clean_out, 8'h00);
      chk("ena_off_rise", rise_pulse, 8'h00);
      ena = 1'b1;
      tick(15);
      chk("ena_re15_clean", clean_out, 8'h00);
      tick(1);
      chk("ena_re16_clean", clean_out, 8'h02);
      chk("ena_re16_rise", rise_pulse, 8'h02);
      add_rise();
      tick(1);
      chk("ena_ev", event_count, ev_exp());

      // reset mid-count clears everything immediately
      raw_in = 8'h06;
      tick(12);
      rst = 1'b1;
      #1;
      chk("mid_rst_clean", clean_out, 8'h00);
      chk("mid_rst_rise", rise_pulse, 8'h00);
      chk("mid_rst_fall", fall_pulse, 8'h00);
      chk("mid_rst_ev", event_count, 8'h00);
      exp_cnt = 0;
      tick(2);
      rst = 1'b0;
      tick(17);
      chk("post_rst_e17", clean_out, 8'h00);
      tick(1);
      chk("post_rst_e18", clean_out, 8'h06);
      chk("post_rst_rise", rise_pulse, 8'h06);
      add_rise();
      tick(1);
      chk("post_rst_ev", event_count, ev_exp());

      // saturation over 300 accepted rises, then clear against a rise
      raw_in = 8'h00;
      tick(20);
      for (int k = 0; k < 300; k++) begin
         raw_in = 8'h01;
         tick(20);
         add_rise();
         raw_in = 8'h00;
         tick(20);
      end
      chk("sat_ev", event_count, ev_exp());
      raw_in = 8'h01;
      tick(18);
      chk("clr_rise", rise_pulse, 8'h01);
      chk("clr_sat_ev", event_count, ev_exp());
      clr_count = 1'b1;
      tick(1);
      clr_count = 1'b0;
      exp_cnt = 0;
      chk("clr_ev", event_count, ev_exp());
      tick(1);
      chk("clr_hold_ev", event_count, ev_exp());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
